rsff_cmd_arbiter: RTL and testbench
===================================

// Module: rsff_cmd_arbiter
// PURPOSE
//  Shares one RS flip-flop (R, S inputs; Q feedback) among N_REQ requesters.
//  - Each requester asks to set or clear Q; a round-robin arbiter picks one command at a time.
//  - An FSM drives S or R for a fixed pulse width, then a settle gap, then acknowledges.
//  - R and S are never asserted together, so the forbidden R=S=1 input is structurally impossible.
// PARAMETERS
//  N_REQ      4  number of requesters (2..16)
//  PULSE_CYC  2  cycles R or S is held high per command (1..255)
//  SETTLE_CYC 1  cycles with R=S=0 after a pulse, before ack (0..255; 0 = no settle state)
// PORTS
//  clk       in   1          rising-edge clock
//  rst       in   1          synchronous reset, active-high
//  set_req   in   N_REQ      set_req[i]=1: requester i asks for Q=1
//  clr_req   in   N_REQ      clr_req[i]=1: requester i asks for Q=0
//  q_in      in   1          Q fed back from the shared RS flip-flop
//  R         out  1          reset drive to the RS flip-flop (registered)
//  S         out  1          set drive to the RS flip-flop (registered)
//  ack       out  N_REQ      one-hot, one-cycle completion strobe to the granted requester
//  grant_id  out  GW         index of the current/last granted requester; GW = max(1, $clog2(N_REQ))
//  busy      out  1          1 whenever state != IDLE
//  err       out  1          one-cycle error strobe (see below)
// BEHAVIOUR
//  Reset values: R=0, S=0, ack=0, grant_id=0, busy=0, err=0, rr_ptr=0, state=IDLE, counter=0.
//  Valid request i: set_req[i] XOR clr_req[i].
//   - If both are 1, request i is ignored.
//   - err pulses in every IDLE cycle in which any requester has both bits set.
//  All outputs are registered. The FSM has four states: IDLE, DRIVE, SETTLE, ACK.
//  IDLE, at cycle t:
//   - Pick the first valid index found searching upward from rr_ptr, wrapping at N_REQ-1.
//   - Latch grant_id and the command (cmd = set or clr).
//   - If the command is redundant (set with q_in=1, or clr with q_in=0): go to ACK; ack fires at t+1.
//   - Otherwise: go to DRIVE; S=1 (set) or R=1 (clr) from cycle t+1.
//  DRIVE: hold the pulse for PULSE_CYC cycles (t+1 .. t+PULSE_CYC).
//   - Go to SETTLE, or to ACK if SETTLE_CYC=0.
//  SETTLE: R=S=0 for SETTLE_CYC cycles, then go to ACK.
//  ACK, one cycle:
//   - ack[grant_id]=1.
//   - err=1 if q_in != expected value (1 for set, 0 for clr).
//   - rr_ptr <= (grant_id+1) mod N_REQ.
//   - Next state: IDLE.
//  Latency with defaults, non-redundant command: S/R high t+1..t+2, settle t+3, ack t+4, IDLE t+5.
//  Requester rules:
//   - Hold the request until ack is seen; drop it in the cycle after ack.
//   - The requester just acked is masked during the first IDLE cycle after ACK, so it is not regranted.
//  Requests are not re-sampled after grant:
//   - A request dropped or changed mid-command does not abort it.
//   - ack is still issued.
//  Simultaneous requests from several requesters: only the round-robin winner proceeds; the others wait, unacknowledged.
//  rst mid-command:
//   - R=S=0 and every output at its reset value on the next edge.
//   - The in-flight command is dropped without ack.
//  Invariants: R&S==0 always; ack is zero or one-hot; busy==0 only in IDLE.
// TESTING
//  1. Reset: rst=1 for 2 cycles with set_req=4'b1111 -> R=S=0, ack=0, busy=0, grant_id=0 throughout.
//  2. Single set, q_in=0: set_req=4'b0010 at t -> S=1 at t+1,t+2; R=0; ack=4'b0010 at t+4; grant_id=1.
//  3. Round-robin: clr_req=4'b1001 held continuously, model toggles q_in ->
//     grants go 0,3,0,3; never R&S=1.
//  4. Redundant: q_in=1, set_req=4'b0100 -> no S pulse, ack=4'b0100 one cycle after grant.
//  5. Conflict/mismatch:
//     - set_req[2]=clr_req[2]=1 -> err=1 each IDLE cycle, no grant.
//     - q_in held 0 during a set -> err=1 with ack.
//  6. Reset mid-DRIVE: assert rst while S=1 -> S=0 next edge, no ack, state IDLE, rr_ptr=0.

Source files
------------

// File: rtl/rsff_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// rsff_cmd_arbiter
//
// Purpose:
//   Lets N_REQ requesters share one external RS flip-flop. Each requester asks
//   for Q=1 (set) or Q=0 (clr). A round-robin arbiter grants one command at a
//   time. An FSM then drives S or R for PULSE_CYC cycles, holds R=S=0 for
//   SETTLE_CYC cycles and acknowledges the granted requester with a one-cycle
//   strobe. R and S come from a single registered command decode, so R=S=1
//   can never be produced.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   set_req      per-requester "drive Q to 1" request
//   clr_req      per-requester "drive Q to 0" request
//   q_in         Q fed back from the shared RS flip-flop
//   R, S         registered reset/set drives to the RS flip-flop
//   ack          one-hot, one-cycle completion strobe to the granted requester
//   grant_id     index of the current/last granted requester
//   busy         high whenever the FSM is not in IDLE
//   err          one-cycle strobe: request conflict seen in IDLE, or Q did
//                not reach the commanded value by the ACK cycle
//   dbg_state_o  current FSM state (IDLE=0, DRIVE=1, SETTLE=2, ACK=3)
//   dbg_rr_ptr_o current round-robin search start index
//
// Handshake:
//   A request is valid while exactly one of set_req[i]/clr_req[i] is high.
//   The requester holds it until it sees ack[i] and drops it the cycle after.
//   Once granted, the command is latched; later changes to the request lines
//   do not affect it and ack is always issued (unless rst intervenes).
// ---------------------------------------------------------------------------
module rsff_cmd_arbiter #(
  parameter int N_REQ      = 4,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 1,
  localparam int GW        = ($clog2(N_REQ) < 1) ? 1 : $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] set_req,
  input  logic [N_REQ-1:0] clr_req,
  input  logic             q_in,
  output logic             R,
  output logic             S,
  output logic [N_REQ-1:0] ack,
  output logic [GW-1:0]    grant_id,
  output logic             busy,
  output logic             err,
  output logic [1:0]       dbg_state_o,
  output logic [GW-1:0]    dbg_rr_ptr_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  // Terminal counts for the DRIVE and SETTLE phases. The counter runs
  // 0 .. N-1 inside each phase and is cleared on every phase change.
  localparam logic [7:0] PULSE_LAST  = 8'(PULSE_CYC - 1);
  localparam logic [7:0] SETTLE_LAST = 8'((SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic             cmd_q, cmd_d;      // 1 = set, 0 = clr
  logic [GW-1:0]    rr_q, rr_d;
  logic             mask_q, mask_d;    // mask grant_q for one IDLE cycle

  logic             r_q, r_d;
  logic             s_q, s_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  // ---------------------------------------------------------------------
  // Request qualification and round-robin pick
  // ---------------------------------------------------------------------
  logic [N_REQ-1:0] valid_req;
  logic             conflict;
  logic             pick_found;
  logic [GW-1:0]    pick_idx;
  logic             pick_cmd;
  logic [GW:0]      sum;
  logic [GW-1:0]    idx;

  assign valid_req = set_req ^ clr_req;
  assign conflict  = |(set_req & clr_req);

  // Scan upward from rr_q with wrap-around; the first valid, unmasked
  // requester wins. sum is one bit wider so rr_q + k cannot overflow.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_cmd   = 1'b0;
    sum        = '0;
    idx        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_q} + (GW+1)'(k);
      if (sum >= (GW+1)'(N_REQ)) begin
        sum = sum - (GW+1)'(N_REQ);
      end
      idx = sum[GW-1:0];
      if (!pick_found && valid_req[idx] && !(mask_q && (idx == grant_q))) begin
        pick_found = 1'b1;
        pick_idx   = idx;
        pick_cmd   = set_req[idx];
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      cmd_q   <= 1'b0;
      rr_q    <= '0;
      mask_q  <= 1'b0;
      r_q     <= 1'b0;
      s_q     <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      cmd_q   <= cmd_d;
      rr_q    <= rr_d;
      mask_q  <= mask_d;
      r_q     <= r_d;
      s_q     <= s_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    cmd_d   = cmd_q;
    rr_d    = rr_q;
    mask_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cmd_d   = pick_cmd;
          cnt_d   = '0;
          // Q already holds the requested value: skip the pulse entirely.
          if (pick_cmd == q_in) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_DRIVE;
          end
        end
      end
      ST_DRIVE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = (SETTLE_CYC == 0) ? ST_ACK : ST_SETTLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        rr_d    = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + GW'(1);
        // The requester just acked still holds its request this cycle;
        // hide it for one IDLE cycle so it is not granted again.
        mask_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: output logic (decoded from next state so outputs are registered
  // and line up with the state they describe)
  // ---------------------------------------------------------------------
  always_comb begin
    s_d    = (state_d == ST_DRIVE) &&  cmd_d;
    r_d    = (state_d == ST_DRIVE) && !cmd_d;
    busy_d = (state_d != ST_IDLE);
    ack_d  = '0;
    if (state_d == ST_ACK) begin
      ack_d[grant_d] = 1'b1;
    end
    // Conflict strobe while idle, or Q mismatch checked on entry to ACK
    // (q_in sampled in the cycle before ACK, reported together with ack).
    err_d = ((state_q == ST_IDLE) && conflict) ||
            ((state_d == ST_ACK) && (q_in != cmd_d));
  end

  assign R            = r_q;
  assign S            = s_q;
  assign ack          = ack_q;
  assign grant_id     = grant_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_q;

endmodule

// File: tb/tb_rsff_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rsff_cmd_arbiter
//
// Bench for rsff_cmd_arbiter with default parameters (N_REQ=4, PULSE_CYC=2,
// SETTLE_CYC=1). A table of per-cycle vectors covers reset, a single set,
// a redundant command, request conflicts and a Q mismatch. Hand-written
// sequences cover reset in the middle of a pulse and round-robin fairness
// with two requesters holding clr continuously.
// Each vector: inputs applied, one rising edge, outputs checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_rsff_cmd_arbiter;

  localparam int N_REQ = 4;
  localparam int GW    = 2;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic [N_REQ-1:0] set_req;
  logic [N_REQ-1:0] clr_req;
  logic             q_in;
  logic             R;
  logic             S;
  logic [N_REQ-1:0] ack;
  logic [GW-1:0]    grant_id;
  logic             busy;
  logic             err;
  logic [1:0]       dbg_state;
  logic [GW-1:0]    dbg_rr_ptr;

  always #5 clk = ~clk;

  rsff_cmd_arbiter #(
    .N_REQ(N_REQ),
    .PULSE_CYC(2),
    .SETTLE_CYC(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .set_req(set_req),
    .clr_req(clr_req),
    .q_in(q_in),
    .R(R),
    .S(S),
    .ack(ack),
    .grant_id(grant_id),
    .busy(busy),
    .err(err),
    .dbg_state_o(dbg_state),
    .dbg_rr_ptr_o(dbg_rr_ptr)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [GW-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             rst;
    logic [N_REQ-1:0] set_req;
    logic [N_REQ-1:0] clr_req;
    logic             q_in;
    logic             r;
    logic             s;
    logic [N_REQ-1:0] ack;
    logic             busy;
    logic [GW-1:0]    gid;
    logic             err;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic r_i, input logic [3:0] sr, input logic [3:0] cr,
                              input logic q, input logic er, input logic es,
                              input logic [3:0] ea, input logic eb,
                              input logic [1:0] eg, input logic ee);
    vec_t v;
    v.rst = r_i; v.set_req = sr; v.clr_req = cr; v.q_in = q;
    v.r = er; v.s = es; v.ack = ea; v.busy = eb; v.gid = eg; v.err = ee;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r_i, input logic [3:0] sr, input logic [3:0] cr,
                       input logic q);
    rst = r_i; set_req = sr; clr_req = cr; q_in = q;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int r_cycles;
  int cyc;
  logic [GW-1:0] eg;

  initial begin
    drive(1'b1, 4'b1111, 4'b0000, 1'b0);

    //                rst  set      clr      q    R  S  ack      busy gid err
    // reset held with every set request active
    vecs[0]  = mk(1, 4'b1111, 4'b0000, 0,   0, 0, 4'b0000, 0,   0,  0);
    vecs[1]  = mk(1, 4'b1111, 4'b0000, 0,   0, 0, 4'b0000, 0,   0,  0);
    // single set from requester 1, Q follows S
    vecs[2]  = mk(0, 4'b0010, 4'b0000, 0,   0, 1, 4'b0000, 1,   1,  0);
    vecs[3]  = mk(0, 4'b0010, 4'b0000, 1,   0, 1, 4'b0000, 1,   1,  0);
    vecs[4]  = mk(0, 4'b0010, 4'b0000, 1,   0, 0, 4'b0000, 1,   1,  0);
    vecs[5]  = mk(0, 4'b0010, 4'b0000, 1,   0, 0, 4'b0010, 1,   1,  0);
    vecs[6]  = mk(0, 4'b0010, 4'b0000, 1,   0, 0, 4'b0000, 0,   1,  0);
    // redundant set from requester 2 with Q already 1
    vecs[7]  = mk(0, 4'b0100, 4'b0000, 1,   0, 0, 4'b0100, 1,   2,  0);
    vecs[8]  = mk(0, 4'b0100, 4'b0000, 1,   0, 0, 4'b0000, 0,   2,  0);
    // requester 2 asserts both bits: err each idle cycle, no grant
    vecs[9]  = mk(0, 4'b0100, 4'b0100, 1,   0, 0, 4'b0000, 0,   2,  1);
    vecs[10] = mk(0, 4'b0100, 4'b0100, 1,   0, 0, 4'b0000, 0,   2,  1);
    vecs[11] = mk(0, 4'b0000, 4'b0000, 1,   0, 0, 4'b0000, 0,   2,  0);
    // set from requester 0 (search wraps from 3) but Q stays 0: err with ack
    vecs[12] = mk(0, 4'b0001, 4'b0000, 0,   0, 1, 4'b0000, 1,   0,  0);
    vecs[13] = mk(0, 4'b0001, 4'b0000, 0,   0, 1, 4'b0000, 1,   0,  0);
    vecs[14] = mk(0, 4'b0001, 4'b0000, 0,   0, 0, 4'b0000, 1,   0,  0);
    vecs[15] = mk(0, 4'b0001, 4'b0000, 0,   0, 0, 4'b0001, 1,   0,  1);
    vecs[16] = mk(0, 4'b0001, 4'b0000, 0,   0, 0, 4'b0000, 0,   0,  0);
    vecs[17] = mk(0, 4'b0000, 4'b0000, 0,   0, 0, 4'b0000, 0,   0,  0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].set_req, vecs[i].clr_req, vecs[i].q_in);
      step();
      chk($sformatf("v%0d_R", i),    int'(R),        int'(vecs[i].r));
      chk($sformatf("v%0d_S", i),    int'(S),        int'(vecs[i].s));
      chk($sformatf("v%0d_ack", i),  int'(ack),      int'(vecs[i].ack));
      chk($sformatf("v%0d_busy", i), int'(busy),     int'(vecs[i].busy));
      chk($sformatf("v%0d_gid", i),  int'(grant_id), int'(vecs[i].gid));
      chk($sformatf("v%0d_err", i),  int'(err),      int'(vecs[i].err));
      if (i == 1) begin
        chk("rst_state", int'(dbg_state), 0);
        chk("rst_rr",    int'(dbg_rr_ptr), 0);
      end
    end
    // requester 0 was last acked, so the search now starts at 1
    chk("rr_after_table", int'(dbg_rr_ptr), 1);

    // ---- reset in the middle of a DRIVE pulse ----
    drive(1'b0, 4'b0010, 4'b0000, 1'b0);
    step();
    chk("mid_S_before", int'(S), 1);
    chk("mid_gid_before", int'(grant_id), 1);
    drive(1'b1, 4'b0010, 4'b0000, 1'b0);
    step();
    chk("mid_S", int'(S), 0);
    chk("mid_R", int'(R), 0);
    chk("mid_ack", int'(ack), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_gid", int'(grant_id), 0);
    chk("mid_state", int'(dbg_state), 0);
    chk("mid_rr", int'(dbg_rr_ptr), 0);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    step();
    chk("mid_no_ack", int'(ack), 0);
    chk("mid_idle", int'(dbg_state), 0);

    // ---- round-robin: requesters 0 and 3 hold clr continuously ----
    // A behavioural RS flop clears Q on R; the bench sets Q back to 1 after
    // each ack so every grant needs a real clr pulse.
    exp_q = '{2'd0, 2'd3, 2'd0, 2'd3};
    drive(1'b0, 4'b0000, 4'b1001, 1'b1);
    r_cycles = 0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 80) begin
      step();
      cyc++;
      if (R && S) begin
        chk("rr_rs_overlap", 1, 0);
      end
      if (R) begin
        r_cycles++;
        q_in = 1'b0;
      end
      if (ack != '0) begin
        eg = exp_q.pop_front();
        chk("rr_ack", int'(ack), 1 << eg);
        chk("rr_gid", int'(grant_id), int'(eg));
        chk("rr_pulse_len", r_cycles, 2);
        chk("rr_err", int'(err), 0);
        r_cycles = 0;
        q_in = 1'b1;
      end
    end
    chk("rr_all_granted", exp_q.size(), 0);
    drive(1'b0, 4'b0000, 4'b0000, 1'b1);
    step();
    step();
    chk("rr_end_idle", int'(busy), 0);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
